// File: rtl/wb_seq_master_pkg.sv
// wb_seq_master_pkg: shared state encoding, default widths and response codes
package wb_seq_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RSP = 2'd2} state_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic RSP_ERR_NONE = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;
endpackage

// File: rtl/wb_seq_master_if.sv
// wb_seq_master_if: command/response channels plus Wishbone classic master bus
interface wb_seq_master_if import wb_seq_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic cmd_we_i;
  logic [ADDR_W-1:0] cmd_adr_i;
  logic [DATA_W-1:0] cmd_dat_i;
  logic [DATA_W/8-1:0] cmd_sel_i;
  logic rsp_valid_o;
  logic rsp_ready_i;
  logic [DATA_W-1:0] rsp_dat_o;
  logic rsp_err_o;
  logic wbm_cyc_o;
  logic wbm_stb_o;
  logic wbm_we_o;
  logic [DATA_W/8-1:0] wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic wbm_ack_i;
  logic [DATA_W-1:0] wbm_dat_i;
  modport master (
    input cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    wbm_adr_o, wbm_dat_o
  );
  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wbm_ack_i, wbm_dat_i,
    input cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: bus-cycle watchdog; expire is high on the last allowed wait cycle
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + TO_W'(1) : cnt;
  assign expire = en && cnt == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/wb_seq_master.sv
// wb_seq_master: one Wishbone classic single access per command, with timeout abort
module wb_seq_master import wb_seq_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  wb_seq_master_if.master bus,
  output logic busy_o,
  output logic stray_ack_o
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUS = BUS;
  localparam logic [1:0] S_RSP = RSP;
  logic [1:0] state;
  logic we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0] rsp_dat;
  logic rsp_err;
  logic stray;
  logic fire;
  logic ack;
  logic expire;
  assign fire = state == S_IDLE && bus.cmd_valid_i;
  assign ack = state == S_BUS && bus.wbm_ack_i;
  wb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timeout (
    .clk(wb_clk_i),
    .rst_n(wb_rst_ni),
    .clr(fire),
    .en(state == S_BUS),
    .expire(expire)
  );
  // ack is checked before expire so an ack on the final allowed cycle still succeeds
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= S_IDLE;
      we <= 1'b0;
      adr <= '0;
      dat <= '0;
      sel <= '0;
      rsp_dat <= '0;
      rsp_err <= RSP_ERR_NONE;
      stray <= 1'b0;
    end else begin
      if (fire) begin
        state <= S_BUS;
        we <= bus.cmd_we_i;
        adr <= bus.cmd_adr_i;
        dat <= bus.cmd_dat_i;
        sel <= bus.cmd_sel_i;
      end else if (ack || expire) begin
        state <= S_RSP;
        rsp_dat <= ack && !we ? bus.wbm_dat_i : '0;
        rsp_err <= ack ? RSP_ERR_NONE : RSP_ERR_TIMEOUT;
      end else if (state == S_RSP && bus.rsp_ready_i) begin
        state <= S_IDLE;
      end
      stray <= stray | (bus.wbm_ack_i & (state != S_BUS));
    end
  assign bus.cmd_ready_o = state == S_IDLE;
  assign bus.rsp_valid_o = state == S_RSP;
  assign bus.rsp_dat_o = rsp_dat;
  assign bus.rsp_err_o = rsp_err;
  assign bus.wbm_cyc_o = state == S_BUS;
  assign bus.wbm_stb_o = state == S_BUS;
  assign bus.wbm_we_o = we;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat;
  assign bus.wbm_sel_o = sel;
  assign busy_o = state != S_IDLE;
  assign stray_ack_o = stray;
endmodule
